// File: rtl/parallel_to_serial_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial frame transmitter.
// Imported by parallel_to_serial and pts_word_counter.
package parallel_to_serial_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pts_state_t;

    // Counter width is max(1, clog2(n)), so a single-word frame still gets a 1-bit counter.
    function automatic int pts_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pts_word_counter.sv
// Word index within the frame being serialized; last flags the final word.
// One-cycle update latency. A synchronous clear takes priority over incr.
module pts_word_counter
    import parallel_to_serial_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = pts_cnt_width(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (incr) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(N_SAMPLES - 1));

endmodule

// File: rtl/parallel_to_serial.sv
// Latches one N_SAMPLES-word frame and emits it word 0 first, one word per send transfer; first word valid the cycle after acceptance.
// Send side stalls indefinitely on send_rdy; PARALLEL_TO_SERIAL_PIPELINE_EN lets a new frame be taken on the last send for zero-bubble streaming.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
    output logic                           send_val,
    input  logic                           send_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg
);

    localparam int CNT_W = pts_cnt_width(N_SAMPLES);

    pts_state_t                     r_state;
    logic [N_SAMPLES*BIT_WIDTH-1:0] r_frame;
    logic [CNT_W-1:0]               w_count;
    logic                           w_last;
    logic                           w_in_idle;
    logic                           w_in_send;
    logic                           w_recv_xfer;
    logic                           w_send_xfer;
    logic [BIT_WIDTH-1:0]           w_word;

    // Outputs are forced low while reset is held, not just after the first edge.
    assign w_in_idle = !reset && (r_state == IDLE);
    assign w_in_send = !reset && (r_state == SEND);

`ifdef PARALLEL_TO_SERIAL_PIPELINE_EN
    assign recv_rdy = w_in_idle | (w_in_send & w_last & send_rdy);
`else
    assign recv_rdy = w_in_idle;
`endif

    assign send_val    = w_in_send;
    assign w_recv_xfer = recv_val & recv_rdy;
    assign w_send_xfer = send_val & send_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_recv_xfer) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    // A frame taken on the last send keeps the FSM in SEND.
                    if (w_send_xfer && w_last && !w_recv_xfer) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame <= '0;
        end else if (w_recv_xfer) begin
            r_frame <= recv_msg;
        end
    end

    pts_word_counter #(
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .clear (w_recv_xfer | (w_send_xfer & w_last)),
        .incr  (w_send_xfer),
        .count (w_count),
        .last  (w_last)
    );

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            if (w_count == CNT_W'(i)) begin
                w_word = r_frame[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign send_msg = w_in_send ? w_word : '0;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Transmit-side counterpart of the parallel-block deserializer control.
- Accepts one frame of N_SAMPLES words on a single val/rdy parallel input and emits the words one per transfer on a val/rdy serial output.
- Datapath and control live in one block: a frame register, a word counter and a 2-state FSM.
- Sits between the FFT/parallel processing output and any word-serial consumer (SPI adapter, FIFO).

Parameters:
- BIT_WIDTH, 32, width of one serial word.
- N_SAMPLES, 8, words per frame; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- recv_val  input  1  parallel frame valid.
- recv_rdy  output  1  block can accept a frame.
- recv_msg  input  N_SAMPLES*BIT_WIDTH  frame; word i = recv_msg[i*BIT_WIDTH +: BIT_WIDTH].
- send_val  output  1  serial word valid.
- send_rdy  input  1  consumer ready.
- send_msg  output  BIT_WIDTH  current serial word.

Behaviour:
- Reset is asynchronous and active-high:
  - state=IDLE, count=0, frame register=0.
  - While reset is high: recv_rdy=0, send_val=0, send_msg=0.
- Counter width is max(1, $clog2(N_SAMPLES)).
- A transfer occurs on a rising edge where val and rdy are both high. No combinational path from send_rdy to recv_rdy, except under the optional feature.

State IDLE:
- recv_rdy=1, send_val=0, send_msg=0.
- On a recv transfer: latch recv_msg into the frame register, count<=0, go to SEND.

State SEND:
- recv_rdy=0, send_val=1, send_msg=frame[count]. Word 0 is sent first.
- send_val is held high and send_msg is held stable until a transfer occurs; the consumer may stall indefinitely.
- On a send transfer with count<N_SAMPLES-1: count<=count+1.
- On a send transfer with count==N_SAMPLES-1 (last word): count<=0, go to IDLE.

Timing and boundaries:
- Latency: first word is valid on the cycle after the recv transfer.
- Minimum frame period is N_SAMPLES+1 cycles (one IDLE bubble).
- N_SAMPLES=1: every frame is a single send; SEND exits on the first transfer.
- recv_val high while in SEND: ignored, since recv_rdy=0. The upstream holds the frame.
- recv_msg changes while in SEND: no effect; the frame register is the only data source.
- Reset mid-frame: the partial frame is discarded and the block is in IDLE on the first clock after deassertion. No word is re-sent.
- send_rdy high in IDLE: no effect.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_PIPELINE_EN.
- Defined:
  - In SEND with count==N_SAMPLES-1, recv_rdy = send_rdy.
  - If both the send transfer and a recv transfer occur on the same edge: latch the new frame, count<=0, stay in SEND.
  - Back-to-back frames then stream with zero bubble (period N_SAMPLES cycles).
- Undefined: behaviour as above; recv_rdy is a pure function of state.

Decomposition:
- Package parallel_to_serial_pkg holds:
  - typedef enum logic {IDLE, SEND} pts_state_t.
  - A function computing counter width max(1, $clog2(n)).
- Sub-module pts_word_counter:
  - Inputs: clk, reset, clear, incr.
  - Outputs: count, last (count==N_SAMPLES-1).
  - Synchronous clear has priority over incr.

Test Plan (BIT_WIDTH=8, N_SAMPLES=4 unless noted):
1. Basic frame: recv_msg=0x44332211 with recv_val high one cycle, send_rdy held 1 -> send_msg 0x11,0x22,0x33,0x44 on 4 consecutive cycles; recv_rdy returns to 1 on the next cycle.
2. Backpressure: same frame, send_rdy toggles 1,0,0,1,0,1,1 -> each word held stable while stalled; exactly 4 transfers in order; no duplicates.
3. Upstream blocked: recv_val held high with a second frame 0xDDCCBBAA during SEND -> recv_rdy=0 until frame 1 completes; frame 2 is then accepted and emitted 0xAA..0xDD.
4. Reset mid-frame: reset asserted asynchronously after 2 words sent -> recv_rdy/send_val fall immediately; after release, a new frame emits from word 0.
5. N_SAMPLES=1: frames 0x5A then 0xA5 -> one send each; state alternates IDLE/SEND.
6. With PARALLEL_TO_SERIAL_PIPELINE_EN, two frames back-to-back, send_rdy=1 -> 8 words on 8 consecutive cycles; send_val never drops between frames.
